// File: rtl/gf163_pkg.sv
// gf163_pkg: shared constants and types for the GF(2^163) inverter.
// Field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;
  localparam int M = 163;
  localparam int MAX_CYC = 650;
  localparam logic [M:0] F_POLY = (164'd1 << 163) | 164'hC9;

  typedef logic [M-1:0] gf_elem_t;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // g / x mod f : add f when g is odd so the shift is exact
  function automatic gf_elem_t gf_half(input gf_elem_t g);
    logic [M:0] t;
    t = g[0] ? ({1'b0, g} ^ F_POLY) : {1'b0, g};
    return t[M:1];
  endfunction
endpackage

// File: rtl/gf163_deg_cmp.sv
// gf163_deg_cmp: compares polynomial degrees of u and v.
// Two priority encoders feed one magnitude compare.
module gf163_deg_cmp
  import gf163_pkg::*;
(
  input  logic [M:0] u,
  input  logic [M:0] v,
  output logic       u_gt_v
);
  logic [7:0] du;
  logic [7:0] dv;

  // highest set bit index of each operand
  always_comb begin
    du = '0;
    dv = '0;
    for (int i = 0; i <= M; i++) begin
      if (u[i]) du = 8'(i);
      if (v[i]) dv = 8'(i);
    end
  end

  assign u_gt_v = du > dv;
endmodule

// File: rtl/gf163_inverter.sv
// gf163_inverter: binary extended Euclid inverter over GF(2^163).
// Optional macro GF_INV_CYCLE_COUNT_EN adds the cycles output.
module gf163_inverter
  import gf163_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [M-1:0]   a,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   o,
  output logic           err
`ifdef GF_INV_CYCLE_COUNT_EN
  ,
  output logic [9:0]     cycles
`endif
);
  state_t     state, state_n;
  logic [M:0] u, u_n, v, v_n;
  gf_elem_t   g1, g1_n, g2, g2_n;
  gf_elem_t   o_n;
  logic [9:0] cyc, cyc_n;
  logic       err_n, busy_n, done_n;
  logic       u_gt_v;

  gf163_deg_cmp u_deg (
    .u      (u),
    .v      (v),
    .u_gt_v (u_gt_v)
  );

  // next-state and datapath update; one Euclid step per RUN cycle
  always_comb begin
    state_n = state;
    u_n     = u;
    v_n     = v;
    g1_n    = g1;
    g2_n    = g2;
    cyc_n   = cyc;
    o_n     = o;
    err_n   = err;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !busy) begin
          u_n    = {1'b0, a};
          v_n    = F_POLY;
          g1_n   = gf_elem_t'(1);
          g2_n   = '0;
          cyc_n  = '0;
          busy_n = 1'b1;
          if (a == '0) begin
            err_n   = 1'b1;
            o_n     = '0;
            state_n = FIN;
          end else begin
            err_n   = 1'b0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        cyc_n = cyc + 10'd1;
        if (u == (M+1)'(1)) begin
          o_n     = g1;
          state_n = FIN;
        end else if (v == (M+1)'(1)) begin
          o_n     = g2;
          state_n = FIN;
        end else if (cyc == 10'(MAX_CYC - 1)) begin
          err_n   = 1'b1;
          o_n     = '0;
          state_n = FIN;
        end else if (!u[0]) begin
          u_n  = u >> 1;
          g1_n = gf_half(g1);
        end else if (!v[0]) begin
          v_n  = v >> 1;
          g2_n = gf_half(g2);
        end else if (u_gt_v) begin
          u_n  = u ^ v;
          g1_n = g1 ^ g2;
        end else begin
          v_n  = v ^ u;
          g2_n = g2 ^ g1;
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      u     <= '0;
      v     <= '0;
      g1    <= '0;
      g2    <= '0;
      cyc   <= '0;
      o     <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      u     <= u_n;
      v     <= v_n;
      g1    <= g1_n;
      g2    <= g2_n;
      cyc   <= cyc_n;
      o     <= o_n;
      err   <= err_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

`ifdef GF_INV_CYCLE_COUNT_EN
  // latch the RUN cycle count alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles <= '0;
    else if (state == FIN) cycles <= cyc;
  end
`endif
endmodule

// File: tb/tb_gf163_inverter.sv
// tb_gf163_inverter: directed + random checks of the GF(2^163) inverter.
// Results are verified by field multiplication in a reference model.
module tb_gf163_inverter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [162:0] a = '0;
  logic         busy, done, err;
  logic [162:0] o;
`ifdef GF_INV_CYCLE_COUNT_EN
  logic [9:0]   cycles;
`endif

  int checks = 0;
  int errors = 0;

  gf163_inverter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .o      (o),
    .err    (err)
`ifdef GF_INV_CYCLE_COUNT_EN
    ,
    .cycles (cycles)
`endif
  );

  always #5 clk = ~clk;

  // polynomial product reduced by x^163 + x^7 + x^6 + x^3 + 1
  function automatic logic [162:0] gmul(input logic [162:0] x,
                                        input logic [162:0] y);
    logic [162:0] r;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      r = r[162] ? ((r << 1) ^ 163'hC9) : (r << 1);
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic logic [162:0] rnd_elem();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (t[162:0] == '0) t[0] = 1'b1;
    return t[162:0];
  endfunction

  task automatic chk(input string tag, input logic [162:0] obs,
                     input logic [162:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // one start pulse; returns result and edges until done (0 on timeout)
  task automatic do_op(input logic [162:0] op, output logic [162:0] ro,
                       output logic re, output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    ro = '0;
    re = 1'b1;
    @(negedge clk);
    a = op;
    start = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done) begin
          seen = 1;
          lat = k;
          ro = o;
          re = err;
        end
      end
    end
  endtask

  logic [162:0] ro, x, a1, a2, a3, r1, r2, inv2;
  logic         re;
  int           lat, ndone, kd, extra;

  initial begin
    inv2 = (163'd1 << 162) | 163'h64;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_o", o, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(163'd1, ro, re, lat);
    chk("one_lat", lat, 3);
    chk("one_o", ro, 1);
    chk("one_err", re, 0);
`ifdef GF_INV_CYCLE_COUNT_EN
    chk("one_cycles", cycles, 1);
`endif

    do_op(163'd2, ro, re, lat);
    chk("x_o", ro, inv2);
    chk("x_err", re, 0);

    do_op(163'd0, ro, re, lat);
    chk("zero_lat", lat, 2);
    chk("zero_err", re, 1);
    chk("zero_o", ro, 0);
    do_op(163'd1, ro, re, lat);
    chk("after_zero_err", re, 0);
    chk("after_zero_o", ro, 1);

    for (int n = 0; n < 80; n++) begin
      x = rnd_elem();
      do_op(x, ro, re, lat);
      chk("rand_prod", gmul(x, ro), 1);
      chk("rand_err", re, 0);
`ifdef GF_INV_CYCLE_COUNT_EN
      chk("rand_cyc_le", (cycles <= 10'd650 && cycles != 0), 1);
`endif
    end

    a1 = rnd_elem() | (163'd1 << 162);
    a2 = rnd_elem() | (163'd1 << 161);
    a3 = rnd_elem();
    r1 = '0;
    r2 = '0;
    ndone = 0;
    kd = 0;
    @(negedge clk);
    a = a1;
    start = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (ndone < 2) begin
        @(posedge clk);
        #1;
        if (done) begin
          ndone++;
          kd = k;
          if (ndone == 1) r1 = o;
          else r2 = o;
        end
        if (k == 5) a = a2;
        if (ndone == 1 && k == kd + 6) a = a3;
        if (ndone == 1 && k == kd + 8) start = 1'b0;
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (700) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("hold_ndone", ndone + extra, 2);
    chk("hold_first", gmul(a1, r1), 1);
    chk("hold_second", gmul(a2, r2), 1);

    @(negedge clk);
    a = rnd_elem() | (163'd1 << 150);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_o", o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(163'd2, ro, re, lat);
    chk("post_rst_o", ro, inv2);
    chk("post_rst_err", re, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
